// File: rtl/alu_mdu.sv
// Multi-cycle RV32I ALU plus RV32M multiply/divide (radix-2 iterative) with valid/ready
// handshakes on both sides; basic ops and divide special cases finish in one cycle.
//
// state | meaning
// IDLE  | in_ready high, waiting for an op
// BUSY  | one shift-add / restoring-divide step per cycle, counter running down
// FIX   | sign correction and high/low or quotient/remainder select
// DONE  | out_valid high, result held until out_ready
module alu_mdu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] y,
   output logic            cmp_taken,
   output logic            illegal
);
   localparam int SHW = $clog2(XLEN);
   localparam int CW  = SHW + 1;

   localparam logic [4:0] OP_ADD  = 5'd1,  OP_SUB    = 5'd2,  OP_AND   = 5'd3,  OP_OR    = 5'd4;
   localparam logic [4:0] OP_XOR  = 5'd5,  OP_SLL    = 5'd6,  OP_SRL   = 5'd7,  OP_SRA   = 5'd8;
   localparam logic [4:0] OP_SLT  = 5'd9,  OP_SLTU   = 5'd10, OP_BEQ   = 5'd11, OP_BNE   = 5'd12;
   localparam logic [4:0] OP_BLT  = 5'd13, OP_MUL    = 5'd14, OP_MULH  = 5'd15, OP_MULHSU = 5'd16;
   localparam logic [4:0] OP_MULHU = 5'd17, OP_DIV   = 5'd18, OP_DIVU  = 5'd19, OP_REM   = 5'd20;
   localparam logic [4:0] OP_REMU = 5'd21;

   typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]     cnt;
   logic [4:0]        op_q;
   logic              neg_q;
   logic [XLEN-1:0]   dv_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   y_q;
   logic              cmp_q, ill_q;

   logic              accept, is_mop, special, a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0]   mag_a, mag_b, basic_y, most_neg;
   logic              basic_cmp, basic_ill;
   logic [SHW-1:0]    shamt;
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0] iter_nxt, fix_prod;
   logic [XLEN-1:0]   fix_q, fix_r, fix_y;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign y         = y_q;
   assign cmp_taken = cmp_q;
   assign illegal   = ill_q;

   assign accept   = in_valid & in_ready & ~flush;
   assign shamt    = b[SHW-1:0];
   assign most_neg = {1'b1, {(XLEN-1){1'b0}}};

   always_comb begin
      basic_y   = '0;
      basic_cmp = 1'b0;
      basic_ill = 1'b0;
      is_mop    = 1'b0;
      special   = 1'b0;
      case (op)
         OP_ADD:  basic_y = a + b;
         OP_SUB:  basic_y = a - b;
         OP_AND:  basic_y = a & b;
         OP_OR:   basic_y = a | b;
         OP_XOR:  basic_y = a ^ b;
         OP_SLL:  basic_y = a << shamt;
         OP_SRL:  basic_y = a >> shamt;
         OP_SRA:  basic_y = $unsigned($signed(a) >>> shamt);
         OP_SLT:  basic_y = XLEN'($signed(a) < $signed(b));
         OP_SLTU: basic_y = XLEN'(a < b);
         OP_BEQ:  basic_cmp = (a == b);
         OP_BNE:  basic_cmp = (a != b);
         OP_BLT:  basic_cmp = ($signed(a) < $signed(b));
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: is_mop = 1'b1;
         OP_DIV, OP_DIVU: begin
            is_mop = 1'b1;
            if (b == '0) begin
               special = 1'b1;
               basic_y = '1;
            end else if (op == OP_DIV && a == most_neg && b == '1) begin
               special = 1'b1;
               basic_y = a;
            end
         end
         OP_REM, OP_REMU: begin
            is_mop = 1'b1;
            if (b == '0) begin
               special = 1'b1;
               basic_y = a;
            end else if (op == OP_REM && a == most_neg && b == '1) begin
               special = 1'b1;
               basic_y = '0;
            end
         end
         default: basic_ill = 1'b1;
      endcase
   end

   assign a_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   assign b_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   assign a_neg = a_sgn & a[XLEN-1];
   assign b_neg = b_sgn & b[XLEN-1];
   assign mag_a = a_neg ? -a : a;
   assign mag_b = b_neg ? -b : b;

   // acc_q holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dv_q} : '0);
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, dv_q};
      if (op_q >= OP_DIV)
         iter_nxt = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
         iter_nxt = {mul_sum, acc_q[XLEN-1:1]};
   end

   always_comb begin
      fix_prod = neg_q ? -acc_q : acc_q;
      fix_q    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      fix_r    = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      case (op_q)
         OP_MUL:                       fix_y = fix_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_y = fix_prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fix_y = fix_q;
         default:                      fix_y = fix_r;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (is_mop && !special) ? BUSY : DONE;
         BUSY:    if (cnt == CW'(1)) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         op_q  <= '0;
         neg_q <= 1'b0;
         dv_q  <= '0;
         acc_q <= '0;
         y_q   <= '0;
         cmp_q <= 1'b0;
         ill_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op_q  <= op;
               neg_q <= (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
               cmp_q <= basic_cmp;
               ill_q <= basic_ill;
               if (is_mop && !special) begin
                  cnt <= CW'(XLEN);
                  if (op >= OP_DIV) begin
                     acc_q <= {{XLEN{1'b0}}, mag_a};
                     dv_q  <= mag_b;
                  end else begin
                     acc_q <= {{XLEN{1'b0}}, mag_b};
                     dv_q  <= mag_a;
                  end
               end else begin
                  y_q <= basic_y;
               end
            end
            BUSY: begin
               acc_q <= iter_nxt;
               cnt   <= cnt - CW'(1);
            end
            FIX:     y_q <= fix_y;
            default: ;
         endcase
      end
   end
endmodule
